fp_round_pack: RTL and testbench

FP_ROUND_PACK -- requirements
Module: fp_round_pack

---
 rtl/fp_round_pack.sv | 169 ++++++++++++++++
 tb/tb_fp_round_pack.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pack.sv
// fp_round_pack: rounds and packs an unpacked divider result into IEEE-754 single.
//
// A captured significand is normalized one bit per cycle (NORM), rounded per the
// captured RISC-V rounding mode (ROUND) and then presented until the consumer
// takes it (DONE). Only one operation is in flight; in_ready is high only in IDLE.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - synchronous active-high reset
//   in_valid  - upstream result valid
//   in_ready  - block can accept (IDLE only)
//   c_s       - result sign
//   c_e       - biased exponent, 8'hFF marks inf/NaN
//   c_m       - significand {hidden, fraction[22:0], guard, round, sticky}
//   rm        - rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others RNE)
//   out_valid - result valid
//   out_ready - consumer accepts result
//   result    - packed single-precision word
//   fflags    - {NV, DZ, OF, UF, NX}; NV and DZ are always 0
module fp_round_pack #(
  parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        c_s,
  input  logic [7:0]  c_e,
  input  logic [26:0] c_m,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  fflags
);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  localparam logic [2:0] RmRne = 3'b000;
  localparam logic [2:0] RmRtz = 3'b001;
  localparam logic [2:0] RmRdn = 3'b010;
  localparam logic [2:0] RmRup = 3'b011;
  localparam logic [2:0] RmRmm = 3'b100;

  state_e      state_q;
  logic        s_q;
  logic [7:0]  e_q;
  logic [26:0] m_q;
  logic [2:0]  rm_q;
  logic [31:0] result_q;
  logic [4:0]  fflags_q;

  // Rounding datapath, evaluated from the captured operand while in ROUND.
  logic        rnd_g, rnd_r, rnd_s, rnd_lsb, rnd_any;
  logic        rnd_inc;
  logic [24:0] rnd_sum;
  logic [23:0] rnd_mant;
  logic [8:0]  rnd_e;
  logic [7:0]  rnd_exp_pk;
  logic        rnd_clamp;
  logic        rnd_away_ovf;
  logic        rnd_of;
  logic [31:0] rnd_result;
  logic [4:0]  rnd_fflags;

  always_comb begin
    rnd_g   = m_q[2];
    rnd_r   = m_q[1];
    rnd_s   = m_q[0];
    rnd_lsb = m_q[3];
    rnd_any = rnd_g | rnd_r | rnd_s;

    case (rm_q)
      RmRtz:   rnd_inc = 1'b0;
      RmRdn:   rnd_inc = s_q & rnd_any;
      RmRup:   rnd_inc = ~s_q & rnd_any;
      RmRmm:   rnd_inc = rnd_g;
      default: rnd_inc = rnd_g & (rnd_r | rnd_s | rnd_lsb); // RNE, also 101-111
    endcase

    rnd_sum = {1'b0, m_q[26:3]} + {24'h0, rnd_inc};
    if (rnd_sum[24]) begin
      rnd_mant = rnd_sum[24:1];
      rnd_e    = {1'b0, e_q} + 9'd1;
    end else begin
      rnd_mant = rnd_sum[23:0];
      rnd_e    = {1'b0, e_q};
    end

    // A subnormal that rounds up into the hidden bit has e == 1 and now packs as normal.
    rnd_exp_pk = rnd_mant[23] ? rnd_e[7:0] : 8'h00;

    // Modes that round toward zero for this sign saturate at max finite.
    rnd_clamp = (rm_q == RmRtz) || ((rm_q == RmRdn) && !s_q) || ((rm_q == RmRup) && s_q);

    // Magnitude beyond max finite: flagged as overflow even when a clamping mode
    // leaves the truncated significand at max finite.
    rnd_away_ovf = (e_q == 8'hFE) && (&m_q[26:3]) && rnd_any;
    rnd_of       = (rnd_e >= 9'd255) || (rnd_clamp && rnd_away_ovf);

    if (rnd_of) begin
      rnd_result = rnd_clamp ? {s_q, 8'hFE, 23'h7FFFFF} : {s_q, 8'hFF, 23'h0};
      rnd_fflags = 5'b00101;
    end else begin
      rnd_result = {s_q, rnd_exp_pk, rnd_mant[22:0]};
      rnd_fflags = {3'b000, rnd_any && (rnd_exp_pk == 8'h00), rnd_any};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      s_q      <= 1'b0;
      e_q      <= 8'h00;
      m_q      <= 27'h0;
      rm_q     <= 3'b000;
      result_q <= 32'h0;
      fflags_q <= 5'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            s_q  <= c_s;
            e_q  <= c_e;
            m_q  <= c_m;
            rm_q <= rm;
            if (c_e == 8'hFF) begin
              result_q <= (c_m != 27'h0) ? NAN_CANON : {c_s, 8'hFF, 23'h0};
              fflags_q <= 5'h0;
              state_q  <= StDone;
            end else if (c_m == 27'h0) begin
              result_q <= {c_s, 31'h0};
              fflags_q <= 5'h0;
              state_q  <= StDone;
            end else begin
              state_q <= StNorm;
            end
          end
        end
        StNorm: begin
          // e <= 1 also stops a zero-exponent operand from wrapping the exponent.
          if (m_q[26] || (e_q <= 8'd1)) begin
            state_q <= StRound;
          end else begin
            m_q <= {m_q[25:0], 1'b0};
            e_q <= e_q - 8'd1;
          end
        end
        StRound: begin
          result_q <= rnd_result;
          fflags_q <= rnd_fflags;
          state_q  <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign fflags    = fflags_q;

endmodule

// File: tb/tb_fp_round_pack.sv
module tb_fp_round_pack;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        c_s;
  logic [7:0]  c_e;
  logic [26:0] c_m;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  fflags;

  int checks;
  int errors;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [26:0] m;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  fl;
    logic [7:0]  lat;
  } vec_t;

  fp_round_pack #(.NAN_CANON(32'h7FC00000)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c_s       (c_s),
    .c_e       (c_e),
    .c_m       (c_m),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .fflags    (fflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation and reports latency (edges from the accepting edge,
  // that edge counted as 1) together with the first valid result.
  task automatic run_op(input logic s, input logic [7:0] e, input logic [26:0] m,
                        input logic [2:0] r, output logic [31:0] res,
                        output logic [4:0] fl, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    c_s = s; c_e = e; c_m = m; rm = r; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs after acceptance; the captured operand must be used.
    c_s = ~s; c_e = 8'h55; c_m = 27'h2AAAAAA; rm = 3'b011;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    res = result;
    fl  = fflags;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_result: got %h want 00000000", result);
    end
    checks++;
    if (fflags !== 5'h0) begin
      errors++; $display("FAIL reset_fflags: got %b want 00000", fflags);
    end
    reset = 1'b0;
  endtask

  task automatic run_table(input string name, input vec_t v[], input int n);
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
    for (int i = 0; i < n; i++) begin
      run_op(v[i].s, v[i].e, v[i].m, v[i].rm, res, fl, lat);
      checks++;
      if (res !== v[i].res) begin
        errors++; $display("FAIL %s[%0d] result: got %h want %h", name, i, res, v[i].res);
      end
      checks++;
      if (fl !== v[i].fl) begin
        errors++; $display("FAIL %s[%0d] fflags: got %b want %b", name, i, fl, v[i].fl);
      end
      checks++;
      if (lat != int'(v[i].lat)) begin
        errors++; $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_normal();
    vec_t v[];
    v = new[4];
    v[0] = '{1'b0, 8'h7F, 27'h4000000, 3'b000, 32'h3F800000, 5'b00000, 8'd3};
    v[1] = '{1'b0, 8'h7F, 27'h0800000, 3'b000, 32'h3E000000, 5'b00000, 8'd6};
    v[2] = '{1'b0, 8'h7F, 27'h0000001, 3'b000, 32'h32800000, 5'b00000, 8'd29};
    v[3] = '{1'b1, 8'h80, 27'h6000000, 3'b001, 32'hC0400000, 5'b00000, 8'd3};
    run_table("normal", v, 4);
  endtask

  task automatic test_rounding();
    vec_t v[];
    v = new[8];
    v[0] = '{1'b0, 8'h7F, 27'h400000C, 3'b000, 32'h3F800002, 5'b00001, 8'd3};
    v[1] = '{1'b0, 8'h7F, 27'h400000C, 3'b001, 32'h3F800001, 5'b00001, 8'd3};
    v[2] = '{1'b1, 8'h7F, 27'h400000C, 3'b011, 32'hBF800001, 5'b00001, 8'd3};
    v[3] = '{1'b1, 8'h7F, 27'h400000C, 3'b010, 32'hBF800002, 5'b00001, 8'd3};
    v[4] = '{1'b0, 8'h7F, 27'h4000004, 3'b100, 32'h3F800001, 5'b00001, 8'd3};
    v[5] = '{1'b0, 8'h7F, 27'h4000004, 3'b000, 32'h3F800000, 5'b00001, 8'd3};
    v[6] = '{1'b0, 8'h7F, 27'h400000C, 3'b101, 32'h3F800002, 5'b00001, 8'd3};
    v[7] = '{1'b0, 8'h7F, 27'h4000001, 3'b011, 32'h3F800001, 5'b00001, 8'd3};
    run_table("round", v, 8);
  endtask

  task automatic test_subnormal();
    vec_t v[];
    v = new[3];
    v[0] = '{1'b0, 8'h01, 27'h0000008, 3'b000, 32'h00000001, 5'b00000, 8'd3};
    v[1] = '{1'b0, 8'h01, 27'h000000C, 3'b000, 32'h00000002, 5'b00011, 8'd3};
    v[2] = '{1'b0, 8'h01, 27'h3FFFFFC, 3'b000, 32'h00800000, 5'b00001, 8'd3};
    run_table("subnorm", v, 3);
  endtask

  task automatic test_overflow();
    vec_t v[];
    v = new[4];
    v[0] = '{1'b0, 8'hFE, 27'h7FFFFFF, 3'b000, 32'h7F800000, 5'b00101, 8'd3};
    v[1] = '{1'b0, 8'hFE, 27'h7FFFFFF, 3'b001, 32'h7F7FFFFF, 5'b00101, 8'd3};
    v[2] = '{1'b1, 8'hFE, 27'h7FFFFFF, 3'b011, 32'hFF7FFFFF, 5'b00101, 8'd3};
    v[3] = '{1'b1, 8'hFE, 27'h7FFFFFF, 3'b010, 32'hFF800000, 5'b00101, 8'd3};
    run_table("ovf", v, 4);
  endtask

  task automatic test_specials();
    vec_t v[];
    v = new[3];
    v[0] = '{1'b1, 8'hFF, 27'h0000000, 3'b000, 32'hFF800000, 5'b00000, 8'd1};
    v[1] = '{1'b1, 8'h40, 27'h0000000, 3'b000, 32'h80000000, 5'b00000, 8'd1};
    v[2] = '{1'b0, 8'hFF, 27'h0000010, 3'b000, 32'h7FC00000, 5'b00000, 8'd1};
    run_table("special", v, 3);
  endtask

  task automatic test_hold();
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
    out_ready = 1'b0;
    run_op(1'b0, 8'hFF, 27'h0000001, 3'b000, res, fl, lat);
    checks++;
    if (lat != 1) begin
      errors++; $display("FAIL hold_latency: got %0d want 1", lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h7FC00000 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: got valid=%b result=%h in_ready=%b want 1 7fc00000 0",
                 i, out_valid, result, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
    int          ghost;
    c_s = 1'b0; c_e = 8'h7F; c_m = 27'h0000001; rm = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b1;  // must lose to reset
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b in_ready=%b result=%h want 0 1 00000000",
               out_valid, in_ready, result);
    end
    ghost = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) ghost++;
    end
    checks++;
    if (ghost != 0) begin
      errors++; $display("FAIL reset_mid_ghost: got %0d valid cycles want 0", ghost);
    end
    run_op(1'b0, 8'h7F, 27'h4000000, 3'b000, res, fl, lat);
    checks++;
    if (res !== 32'h3F800000 || fl !== 5'h0 || lat != 3) begin
      errors++;
      $display("FAIL reset_mid_next: got %h %b lat %0d want 3f800000 00000 lat 3", res, fl, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
    run_op(1'b0, 8'hFF, 27'h0, 3'b000, res, fl, lat);
    // Leaving DONE: in_ready must be low in the DONE cycle itself.
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_overlap: got in_ready %b want 0", in_ready);
    end
    run_op(1'b1, 8'h7F, 27'h400000C, 3'b000, res, fl, lat);
    checks++;
    if (res !== 32'hBF800002 || fl !== 5'b00001 || lat != 3) begin
      errors++;
      $display("FAIL b2b_second: got %h %b lat %0d want bf800002 00001 lat 3", res, fl, lat);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    c_s       = 1'b0;
    c_e       = 8'h0;
    c_m       = 27'h0;
    rm        = 3'b000;
    test_reset();
    test_normal();
    test_rounding();
    test_subnormal();
    test_overflow();
    test_specials();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
